uart_tx: RTL and testbench
==========================

# uart_tx

Memory-mapped UART transmitter that takes bytes from the core over the same load/store strobe interface the CLINT and terminal UART use. It buffers the bytes in a TX FIFO and serializes them as 8N1 frames on a physical TX pin. It sits on the core's peripheral bus next to the terminal UART and drives the board-level serial line. It also raises a level interrupt when the FIFO drains.

## Interface
- `CLK_DIV`, 868: clock cycles per serial bit. Must be ≥ 2. 868 gives 115200 baud at 100 MHz.
- `FIFO_DEPTH`, 16: TX FIFO entries. Must be a power of two, ≥ 2.
- `ADDR_W`, `$clog2(UART_MEM_SIZE)`: byte-address width.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_re`  in  1  read strobe.
- `i_we`  in  1  write strobe.
- `i_addr`  in  ADDR_W  byte address. Decode uses `i_addr[3:2]`; other bits are ignored.
- `i_wdata`  in  XLEN  write data.
- `o_rdata`  out  XLEN  read data. Combinational from `i_addr`.
- `o_txd`  out  1  serial line, idle high. Registered.
- `o_irq`  out  1  TX-empty interrupt, level. Registered.

## Operation
- Register map (word offsets):
  - 0x0 TXDATA
    - W: push `i_wdata[7:0]`.
    - R: 0.
  - 0x4 STATUS
    - R: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8+:$clog2(FIFO_DEPTH)+1] count. All other bits 0.
    - W: any write clears overflow.
  - 0x8 CTRL
    - RW: bit0 enable, bit1 irq_en. Other bits read 0.
  - 0xC: reads 0, writes ignored.
- `i_re` has no side effects. `o_rdata` is valid whenever the address is stable.
- Push while full: the byte is dropped and overflow is set. "Full" is sampled before any same-cycle pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when enable && !empty. The head byte is popped into the shift register on that edge.
  - START: drive 0 for CLK_DIV cycles → DATA.
  - DATA: drive shift[0] for CLK_DIV cycles per bit, LSB first. A 3-bit bit counter runs 0..7; at 7, go to STOP.
  - STOP: drive 1 for CLK_DIV cycles. Then:
    - → START with a pop, if enable && !empty (back-to-back frames, no idle gap);
    - else → IDLE.
- Baud counter is `$clog2(CLK_DIV)` bits. It reloads to 0 on every state/bit transition and counts to CLK_DIV-1.
- Clearing enable mid-frame: the current frame completes and no further pops occur. FIFO contents are retained.
- `o_irq` = irq_en && empty && FSM==IDLE, registered.

## Timing
- Reset values:
  - `o_txd`=1, `o_irq`=0.
  - FSM=IDLE, FIFO empty (count 0).
  - overflow=0, CTRL=0, counters 0.
- Reset asserted mid-frame: `o_txd` goes 1 immediately (asynchronously) and the FIFO empties. On release the block is idle.
- Write to TXDATA at edge N, with enable set, FIFO empty and FSM IDLE:
  - entry visible at N;
  - pop and START at edge N+1;
  - `o_txd` low from N+1.
- A frame occupies exactly 10·CLK_DIV cycles on `o_txd`.
- A STATUS read is combinational. A push or pop at edge N is reflected in count from edge N.
- Simultaneous push and pop:
  - not full: count is unchanged and both take effect;
  - full: the pop succeeds and the push is dropped, setting overflow.
- Simultaneous write to STATUS and an overflowing push to TXDATA: not possible, since there is a single address per cycle.
- `o_irq` lags its condition by one cycle.

## Structure
- `cotm32_pkg`:
  - `UART_TX_TXDATA`/`STATUS`/`CTRL` offset constants;
  - STATUS/CTRL bit-index constants;
  - `uart_tx_state_e` enum {IDLE, START, DATA, STOP}.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata (head, show-ahead), full, empty, count;
  - pointers are log2(DEPTH)+1 bits wide for full/empty disambiguation.
- `uart_tx` holds the register decode, the FSM, the baud and bit counters, and the shift register.

## Test plan
- Reset then idle: after `i_rst` deasserts, `o_txd`=1, STATUS read = 0x0000_0002 (empty), `o_irq`=0 → all hold for 100 cycles.
- Single byte: CTRL=0x1, write 0xA5 to TXDATA (CLK_DIV=4) → `o_txd` low from the next edge; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high; busy clears after 40 cycles.
- Back-to-back: push 0x00, 0xFF, 0x55 → three contiguous 10-bit frames, 120 cycles at CLK_DIV=4, with no idle cycle between stop and the next start.
- Overflow: enable=0, push 17 bytes into FIFO_DEPTH=16 → STATUS full=1, count=16, overflow=1. Write to STATUS → overflow=0. Set enable → 16 frames; the 17th byte never appears.
- Interrupt: CTRL=0x3, push one byte → `o_irq` low during the frame and high one cycle after FSM returns to IDLE. Clear irq_en → `o_irq` low the next cycle.
- Reset mid-frame: assert `i_rst` during DATA bit 3 with 4 bytes queued → `o_txd`=1 immediately, count=0 after release, and no further frames.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants and types for the memory-mapped UART transmitter.
//   - bus data width and peripheral window size
//   - register byte offsets (decoded on addr[3:2])
//   - STATUS / CTRL bit positions
//   - transmitter FSM state type
package uart_tx_pkg;

  localparam int XLEN          = 32;
  localparam int UART_MEM_SIZE = 16;

  localparam logic [3:0] UART_TX_TXDATA = 4'h0;
  localparam logic [3:0] UART_TX_STATUS = 4'h4;
  localparam logic [3:0] UART_TX_CTRL   = 4'h8;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  // Word index of a register byte offset, as seen by the address decoder.
  function automatic logic [1:0] reg_index(input logic [3:0] offset);
    return offset[3:2];
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: load/store strobe bus between the core (master) and the UART
// transmitter (slave).
//   re    : read strobe (no side effects in the transmitter)
//   we    : write strobe
//   addr  : byte address
//   wdata : write data
//   rdata : read data, combinational from addr
interface uart_tx_if
  import uart_tx_pkg::*;
#(
  parameter int ADDR_W = $clog2(UART_MEM_SIZE)
);

  logic              re;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;

  modport master (
    output re,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  re,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst : clock, asynchronous active-high reset (pointers only)
//   push     : write wdata (ignored while full)
//   pop      : advance head (ignored while empty)
//   rdata    : current head entry
//   full, empty, count : occupancy, derived from pointers before this edge
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rdata   = mem[rd_ptr_q[AW-1:0]];
  // Full is judged before any same-cycle pop, so a push into a full FIFO is
  // dropped even when a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : load/store strobe bus (slave side)
//            0x0 TXDATA  W: push wdata[7:0]          R: 0
//            0x4 STATUS  R: full/empty/busy/ovf/count W: clear overflow
//            0x8 CTRL    RW: bit0 enable, bit1 irq_en
//            0xC         reads 0, writes ignored
//   o_txd  : serial line, idle high, registered
//   o_irq  : level interrupt, irq_en && FIFO empty && FSM idle, registered
// CLK_DIV (>= 2) is cycles per bit; FIFO_DEPTH is a power of two >= 2.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = $clog2(UART_MEM_SIZE)
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave bus,
  output logic     o_txd,
  output logic     o_irq
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              irq_q, irq_d;
  logic              en_q, en_d;
  logic              irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d;

  logic [ADDR_W-1:0] addr;
  logic [1:0]        sel;
  logic              wr_txdata;
  logic              wr_status;
  logic              wr_ctrl;
  logic              baud_done;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  // Reads have no side effects and only part of the address/data is decoded.
  logic              unused_bus;
  assign unused_bus = ^{bus.re, addr, bus.wdata};

  assign addr      = bus.addr;
  assign sel       = addr[3:2];
  assign wr_txdata = bus.we && (sel == reg_index(UART_TX_TXDATA));
  assign wr_status = bus.we && (sel == reg_index(UART_TX_STATUS));
  assign wr_ctrl   = bus.we && (sel == reg_index(UART_TX_CTRL));
  assign fifo_push = wr_txdata && !fifo_full;
  assign baud_done = (baud_q == BAUD_W'(CLK_DIV - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control registers. Only one address per cycle, so a STATUS write and an
  // overflowing TXDATA push never coincide.
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (wr_ctrl) begin
      en_d     = bus.wdata[CTRL_EN_BIT];
      irq_en_d = bus.wdata[CTRL_IRQ_EN_BIT];
    end
    if (wr_status) ovf_d = 1'b0;
    if (wr_txdata && fifo_full) ovf_d = 1'b1;
  end

  always_comb begin
    bus.rdata = '0;
    case (sel)
      reg_index(UART_TX_STATUS): begin
        bus.rdata[STATUS_FULL_BIT]               = fifo_full;
        bus.rdata[STATUS_EMPTY_BIT]              = fifo_empty;
        bus.rdata[STATUS_BUSY_BIT]               = (state_q != IDLE);
        bus.rdata[STATUS_OVF_BIT]                = ovf_q;
        bus.rdata[STATUS_COUNT_LSB +: CNT_W]     = fifo_count;
      end
      reg_index(UART_TX_CTRL): begin
        bus.rdata[CTRL_EN_BIT]     = en_q;
        bus.rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      default: bus.rdata = '0;
    endcase
  end

  // Frame sequencer. Every state/bit transition reloads the baud counter, so
  // each of the 10 bit slots lasts exactly CLK_DIV cycles. STOP may chain
  // straight into START for back-to-back frames.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q && !fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (en_q && !fifo_empty) begin
            state_d  = START;
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // The line is registered from the next state so it changes on the same
    // edge as the state it represents.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign irq_d = irq_en_q && fifo_empty && (state_q == IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
      irq_q    <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      irq_q    <= irq_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
    end
  end

  // Shift data is only meaningful while a frame is in flight.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

  assign o_txd = txd_q;
  assign o_irq = irq_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLK_DIV=4, FIFO_DEPTH=16.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;

  logic clk = 1'b0;
  logic rst;
  logic txd;
  logic irq;

  uart_tx_if #(.ADDR_W(AW)) bus ();

  uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_txd (txd),
    .o_irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_lo = 0;
  int irq_hi  = 0;

  typedef struct {
    logic        we;
    logic [3:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.addr  = off;
    bus.wdata = data;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    bus.re   = 1'b1;
    bus.addr = off;
    #1;
    chk(name, bus.rdata, exp);
    bus.re = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    bus.we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge on which a frame's start bit begins.
  task automatic check_frame(input logic [7:0] data, input string tag);
    logic [9:0]         frame;
    logic [CLK_DIV-1:0] got;
    frame    = {1'b1, data, 1'b0};
    bus.addr = UART_TX_STATUS;
    #1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        got[c] = txd;
        if (!bus.rdata[STATUS_BUSY_BIT]) busy_lo++;
        if (irq) irq_hi++;
        @(posedge clk);
        #1;
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(got), 32'({CLK_DIV{frame[b]}}));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad_txd, bad_irq, bad_stat;

    vecs[0]  = '{1'b0, 4'h4, 32'h0,         32'h2};
    vecs[1]  = '{1'b0, 4'h8, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 4'h8, 32'hFFFF_FFFE, 32'h0};
    vecs[5]  = '{1'b0, 4'h8, 32'h0,         32'h2};
    vecs[6]  = '{1'b1, 4'h8, 32'h0,         32'h0};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0111, 32'h0};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,         32'h100};
    vecs[10] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, 4'h4, 32'h0,         32'h100};
    vecs[12] = '{1'b0, 4'hC, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 4'h0, 32'h22,        32'h0};
    vecs[14] = '{1'b0, 4'h4, 32'h0,         32'h200};
    vecs[15] = '{1'b1, 4'h4, 32'h0,         32'h0};
    vecs[16] = '{1'b0, 4'h6, 32'h0,         32'h200};
    vecs[17] = '{1'b0, 4'h0, 32'h0,         32'h0};
    vecs[18] = '{1'b0, 4'h8, 32'h0,         32'h0};

    bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    read_chk("rst_status", UART_TX_STATUS, 32'h2);
    @(negedge clk);
    rst = 1'b0;

    // Idle for 100 cycles after release
    bad_txd = 0; bad_irq = 0; bad_stat = 0;
    bus.addr = UART_TX_STATUS;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) bad_txd++;
      if (irq !== 1'b0) bad_irq++;
      if (bus.rdata !== 32'h2) bad_stat++;
    end
    chk("idle_txd_bad_cycles", 32'(bad_txd), 32'd0);
    chk("idle_irq_bad_cycles", 32'(bad_irq), 32'd0);
    chk("idle_status_bad_cycles", 32'(bad_stat), 32'd0);

    // Register decode table
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].we) bus_write(vecs[i].off, vecs[i].data);
      else read_chk($sformatf("vec%0d_rdata", i), vecs[i].off, vecs[i].exp);
    end

    // Single byte 0xA5
    do_reset();
    bus_write(UART_TX_CTRL, 32'h1);
    bus_write(UART_TX_TXDATA, 32'hA5);
    read_chk("single_status_pushed", UART_TX_STATUS, 32'h100);
    chk("single_txd_before", 32'(txd), 32'd1);
    @(posedge clk);
    #1;
    busy_lo = 0;
    check_frame(8'hA5, "single");
    chk("single_busy_low_in_frame", 32'(busy_lo), 32'd0);
    read_chk("single_status_after", UART_TX_STATUS, 32'h2);
    chk("single_txd_after", 32'(txd), 32'd1);

    // Back-to-back frames
    do_reset();
    bus_write(UART_TX_TXDATA, 32'h00);
    bus_write(UART_TX_TXDATA, 32'hFF);
    bus_write(UART_TX_TXDATA, 32'h55);
    read_chk("b2b_status_queued", UART_TX_STATUS, 32'h300);
    bus_write(UART_TX_CTRL, 32'h1);
    @(posedge clk);
    #1;
    busy_lo = 0;
    check_frame(8'h00, "b2b0");
    check_frame(8'hFF, "b2b1");
    check_frame(8'h55, "b2b2");
    chk("b2b_busy_low_in_frames", 32'(busy_lo), 32'd0);
    read_chk("b2b_status_after", UART_TX_STATUS, 32'h2);

    // Overflow, then a push that coincides with the first pop while full
    do_reset();
    for (int i = 0; i < 17; i++) bus_write(UART_TX_TXDATA, 32'(i));
    read_chk("ovf_status_full", UART_TX_STATUS, 32'h1009);
    bus_write(UART_TX_STATUS, 32'h0);
    read_chk("ovf_status_cleared", UART_TX_STATUS, 32'h1001);
    bus_write(UART_TX_CTRL, 32'h1);
    bus_write(UART_TX_TXDATA, 32'hEE);
    read_chk("ovf_status_push_pop_full", UART_TX_STATUS, 32'h0F0C);
    for (int i = 0; i < 16; i++) check_frame(8'(i), $sformatf("ovf_f%0d", i));
    read_chk("ovf_status_drained", UART_TX_STATUS, 32'h000A);
    bad_txd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) bad_txd++;
    end
    chk("ovf_no_extra_frame", 32'(bad_txd), 32'd0);

    // Interrupt
    do_reset();
    bus_write(UART_TX_TXDATA, 32'h3C);
    bus_write(UART_TX_CTRL, 32'h3);
    chk("irq_after_enable", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    irq_hi = 0;
    check_frame(8'h3C, "irq");
    chk("irq_high_in_frame", 32'(irq_hi), 32'd0);
    chk("irq_at_idle_entry", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    chk("irq_one_after_idle", 32'(irq), 32'd1);
    bus_write(UART_TX_CTRL, 32'h1);
    chk("irq_lag_on_disable", 32'(irq), 32'd1);
    @(posedge clk);
    #1;
    chk("irq_after_disable", 32'(irq), 32'd0);

    // Reset in the middle of data bit 3
    do_reset();
    for (int i = 0; i < 4; i++) bus_write(UART_TX_TXDATA, 32'h00);
    bus_write(UART_TX_CTRL, 32'h1);
    repeat (18) @(posedge clk);
    #1;
    read_chk("midrst_status_before", UART_TX_STATUS, 32'h304);
    chk("midrst_txd_before", 32'(txd), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_txd_async", 32'(txd), 32'd1);
    read_chk("midrst_status_in_reset", UART_TX_STATUS, 32'h2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    read_chk("midrst_status_after", UART_TX_STATUS, 32'h2);
    read_chk("midrst_ctrl_after", UART_TX_CTRL, 32'h0);
    bus_write(UART_TX_CTRL, 32'h1);
    bad_txd = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) bad_txd++;
    end
    chk("midrst_no_frames", 32'(bad_txd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
